ctrl_mem_arb: RTL

Parametrised successor of the byte-serial memory controller. It arbitrates a single 8-bit-data RAM port between instruction fetch (IF) and load/store (MEM). The RAM read latency, word size and address width are configurable. IF fetches can be aborted mid-transfer, and the block has a deterministic one-cycle completion/turnaround state. It sits between the IF/MEM pipeline stages and the external RAM interface.

---
 rtl/ctrl_mem_arb.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ctrl_mem_arb.sv
// ctrl_mem_arb: arbitrates one byte-wide RAM port between instruction fetch and load/store,
// serialising words into byte transfers with a configurable RAM read latency.
module ctrl_mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4,
    parameter int RD_LAT     = 1,
    parameter int LEN_W      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    if_discard,
    input  logic                    if_read,
    input  logic [ADDR_W-1:0]       if_addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [8*WORD_BYTES-1:0] mem_wdata,
    input  logic [LEN_W-1:0]        mem_length,
    input  logic                    mem_signed,
    output logic                    ram_rw,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [7:0]              ram_w_data,
    input  logic [7:0]              ram_r_data,
    output logic                    if_busy,
    output logic                    if_ready,
    output logic [8*WORD_BYTES-1:0] if_data,
    output logic                    mem_busy,
    output logic                    mem_ready,
    output logic [8*WORD_BYTES-1:0] mem_rdata
);
    localparam int WW    = 8 * WORD_BYTES;
    localparam int CNT_W = LEN_W + 2;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_d;
    logic              serve_if, serve_if_d, sgn, sgn_d;
    logic [CNT_W-1:0]  cnt, cnt_d, len, len_d, idx;
    logic [ADDR_W-1:0] base, base_d, ram_addr_d;
    logic [WW-1:0]     rx, rx_d, rx_next, keep, fill, ext, if_data_d, mem_rdata_d;
    logic [7:0]        top, ram_w_data_d;
    logic              ram_rw_d, if_busy_d, if_ready_d, mem_busy_d, mem_ready_d;

    // cnt = number of edges since acceptance; byte (cnt-1-RD_LAT) is on ram_r_data now
    always_comb begin
        idx     = cnt - CNT_W'(RD_LAT + 1);
        rx_next = (cnt > CNT_W'(RD_LAT)) ? (rx | (WW'(ram_r_data) << {idx, 3'b0})) : rx;
        keep    = ~({WW{1'b1}} << {len, 3'b0});
        top     = 8'(rx_next >> {len - CNT_W'(1), 3'b0});
        fill    = {WW{sgn & top[7]}};
        ext     = (rx_next & keep) | (fill & ~keep);
    end

    always_comb begin
        state_d       = state;
        serve_if_d    = serve_if;
        sgn_d         = sgn;
        cnt_d         = cnt;
        len_d         = len;
        base_d        = base;
        rx_d          = rx;
        ram_rw_d      = ram_rw;
        ram_addr_d    = ram_addr;
        ram_w_data_d  = ram_w_data;
        if_busy_d     = if_busy;
        mem_busy_d    = mem_busy;
        if_ready_d    = 1'b0;
        mem_ready_d   = 1'b0;
        if_data_d     = if_data;
        mem_rdata_d   = mem_rdata;
        case (state)
            IDLE: begin
                ram_rw_d   = 1'b0;
                ram_addr_d = '0;
                cnt_d      = CNT_W'(1);
                rx_d       = '0;
                if (mem_write || mem_read) begin
                    serve_if_d = 1'b0;
                    sgn_d      = mem_signed;
                    len_d      = CNT_W'(mem_length);
                    base_d     = mem_addr;
                    if (mem_length == '0) begin
                        state_d     = DONE;
                        mem_ready_d = 1'b1;
                    end else begin
                        state_d      = mem_write ? WRITE : READ;
                        if_busy_d    = 1'b1;
                        ram_rw_d     = mem_write;
                        ram_addr_d   = mem_addr;
                        ram_w_data_d = mem_wdata[7:0];
                    end
                end else if (if_read && !if_discard) begin
                    serve_if_d = 1'b1;
                    sgn_d      = 1'b0;
                    len_d      = CNT_W'(WORD_BYTES);
                    base_d     = if_addr;
                    state_d    = READ;
                    mem_busy_d = 1'b1;
                    ram_addr_d = if_addr;
                end
            end
            READ: begin
                cnt_d = cnt + CNT_W'(1);
                rx_d  = rx_next;
                if (serve_if && if_discard) begin
                    state_d    = IDLE;
                    mem_busy_d = 1'b0;
                    ram_addr_d = '0;
                end else if (cnt == len + CNT_W'(RD_LAT)) begin
                    state_d    = DONE;
                    ram_addr_d = '0;
                    if_busy_d  = 1'b0;
                    mem_busy_d = 1'b0;
                    if (serve_if) begin
                        if_ready_d = 1'b1;
                        if_data_d  = rx_next;
                    end else begin
                        mem_ready_d = 1'b1;
                        mem_rdata_d = ext;
                    end
                end else if (cnt < len) begin
                    ram_addr_d = base + ADDR_W'(cnt);
                end
            end
            WRITE: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt < len) begin
                    ram_addr_d   = base + ADDR_W'(cnt);
                    ram_w_data_d = 8'(mem_wdata >> {cnt, 3'b0});
                end else begin
                    state_d     = DONE;
                    ram_rw_d    = 1'b0;
                    ram_addr_d  = '0;
                    if_busy_d   = 1'b0;
                    mem_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            serve_if   <= 1'b0;
            sgn        <= 1'b0;
            cnt        <= '0;
            len        <= '0;
            base       <= '0;
            rx         <= '0;
            ram_rw     <= 1'b0;
            ram_addr   <= '0;
            ram_w_data <= '0;
            if_busy    <= 1'b0;
            mem_busy   <= 1'b0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            if_data    <= '0;
            mem_rdata  <= '0;
        end else begin
            state      <= state_d;
            serve_if   <= serve_if_d;
            sgn        <= sgn_d;
            cnt        <= cnt_d;
            len        <= len_d;
            base       <= base_d;
            rx         <= rx_d;
            ram_rw     <= ram_rw_d;
            ram_addr   <= ram_addr_d;
            ram_w_data <= ram_w_data_d;
            if_busy    <= if_busy_d;
            mem_busy   <= mem_busy_d;
            if_ready   <= if_ready_d;
            mem_ready  <= mem_ready_d;
            if_data    <= if_data_d;
            mem_rdata  <= mem_rdata_d;
        end
    end
endmodule
